// File: rtl/gf_factor_gen_4_masked.sv
// Masked GF(2^4) shared-factor generator: per-share linear expansion F behind a
// glitch-barrier stage register, then a DEPTH-entry output FIFO. Optional remasking: GF_FACTOR_REMASK_EN.
module gf_factor_gen_4_masked #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a0,
  input  logic [3:0] in_a1,
  input  logic [3:0] in_b0,
  input  logic [3:0] in_b1,
  input  logic [7:0] in_rnd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_fa0,
  output logic [8:0] out_fa1,
  output logic [8:0] out_fb0,
  output logic [8:0] out_fb1,
  output logic [2:0] level
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);
  localparam logic [1:0] LAST_L  = 2'(DEPTH - 1);

  // F is linear, so it is applied to one share at a time and never mixes shares.
  function automatic logic [8:0] factor_f(input logic [3:0] x);
    logic [1:0] h, l, s;
    h = x[3:2];
    l = x[1:0];
    s = h ^ l;
    return {s[1] ^ s[0], s, h[1] ^ h[0], h, l[1] ^ l[0], l};
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_L) ? 2'd0 : p + 2'd1;
  endfunction

  logic        stg_vld_q, stg_vld_d;
  logic [15:0] stg_q, stg_d;
  logic [35:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  level_q, level_d;
  logic        full, pop, push, acc;
  logic [35:0] entry, head;

  assign full     = (level_q == DEPTH_L);
  assign out_valid = (level_q != 3'd0);
  assign pop      = out_valid & out_ready;
  assign push     = stg_vld_q & (~full | pop);
  assign in_ready = ~stg_vld_q | push;
  assign acc      = in_valid & in_ready;
  assign level    = level_q;

  always_comb begin
    stg_d = {in_a0, in_a1, in_b0, in_b1};
`ifdef GF_FACTOR_REMASK_EN
    stg_d = stg_d ^ {in_rnd[3:0], in_rnd[3:0], in_rnd[7:4], in_rnd[7:4]};
`endif
  end

`ifndef GF_FACTOR_REMASK_EN
  logic unused_rnd;
  assign unused_rnd = ^in_rnd;
`endif

  always_comb begin
    stg_vld_d = stg_vld_q;
    if (acc)       stg_vld_d = 1'b1;
    else if (push) stg_vld_d = 1'b0;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  assign entry = {factor_f(stg_q[15:12]), factor_f(stg_q[11:8]),
                  factor_f(stg_q[7:4]),   factor_f(stg_q[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      level_q   <= 3'd0;
    end else if (flush) begin
      stg_vld_q <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      level_q   <= 3'd0;
    end else begin
      stg_vld_q <= stg_vld_d;
      level_q   <= level_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Data path carries no reset; validity is tracked by the control flops above.
  always_ff @(posedge clk) begin
    if (acc)  stg_q <= stg_d;
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign head    = out_valid ? mem_q[rd_ptr_q] : 36'd0;
  assign out_fa0 = head[35:27];
  assign out_fa1 = head[26:18];
  assign out_fb0 = head[17:9];
  assign out_fb1 = head[8:0];

endmodule

// File: tb/tb_gf_factor_gen_4_masked.sv
// Directed and randomized bench for gf_factor_gen_4_masked (default DEPTH).
module tb_gf_factor_gen_4_masked;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_a0, in_a1, in_b0, in_b1;
  logic [7:0] in_rnd;
  logic [8:0] out_fa0, out_fa1, out_fb0, out_fb1;
  logic [2:0] level;

  int n_cmp = 0;
  int n_fail = 0;
  int next_in, next_out;

  gf_factor_gen_4_masked #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_rnd(in_rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fa0(out_fa0), .out_fa1(out_fa1), .out_fb0(out_fb0), .out_fb1(out_fb1),
    .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] fm(input logic [3:0] x);
    logic [1:0] h, l, s;
    h = x[3:2];
    l = x[1:0];
    s = h ^ l;
    return {s[1] ^ s[0], s, h[1] ^ h[0], h, l[1] ^ l[0], l};
  endfunction

  function automatic logic [3:0] va(input int i);
    logic [3:0] v;
    v = 4'(i);
    return v ^ 4'h3;
  endfunction

  function automatic logic [3:0] vb(input int i);
    logic [3:0] v;
    v = ~4'(i);
    return v ^ 4'h9;
  endfunction

  task automatic set_beat(input int i);
    in_a0 = 4'(i); in_a1 = 4'h3; in_b0 = ~4'(i); in_b1 = 4'h9; in_rnd = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if ({out_fa0, out_fa1, out_fb0, out_fb1} !== 36'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {out_fa0, out_fa1, out_fb0, out_fb1}); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL pop_empty_level got=%0d exp=0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_a0 = 4'h5; in_a1 = 4'h0; in_b0 = 4'hA; in_b1 = 4'h0; in_rnd = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early got=%b exp=0", out_valid); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL basic_level1 got=%0d exp=1", level); end
    n_cmp++; if ({out_fa0, out_fa1, out_fb0, out_fb1} !== {9'h02D, 9'h000, 9'h036, 9'h000})
      begin n_fail++; $display("FAIL basic_data got=%h %h %h %h exp=02d 000 036 000", out_fa0, out_fa1, out_fb0, out_fb1); end
    @(negedge clk); #1;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_level0 got=%0d/%b exp=0/0", level, out_valid); end
  endtask

  task automatic test_remask();
    logic [8:0] e0, e1;
`ifdef GF_FACTOR_REMASK_EN
    e0 = 9'h02D; e1 = 9'h0C3;
`else
    e0 = 9'h0EE; e1 = 9'h000;
`endif
    @(negedge clk);
    in_a0 = 4'h6; in_a1 = 4'h0; in_b0 = 4'h0; in_b1 = 4'h0; in_rnd = 8'h03;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_rnd = 8'h00;
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_fa0 !== e0 || out_fa1 !== e1)
      begin n_fail++; $display("FAIL remask_data got=%b %h %h exp=1 %h %h", out_valid, out_fa0, out_fa1, e0, e1); end
    n_cmp++; if ((out_fa0 ^ out_fa1) !== 9'h0EE) begin n_fail++; $display("FAIL remask_unmasked got=%h exp=0ee", out_fa0 ^ out_fa1); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc;
    logic [8:0] held;
    acc = 0; next_in = 1; next_out = 1; out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; set_beat(next_in); #1;
      if (in_ready && acc < DEPTH + 2) begin acc++; next_in++; end
    end
    @(negedge clk); set_beat(next_in); #1;
    n_cmp++; if (acc != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, DEPTH + 1); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (level !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_level got=%0d exp=%0d", level, DEPTH); end
    held = out_fa0;
    @(negedge clk); #1;
    n_cmp++; if (out_fa0 !== held || (out_fa0 ^ out_fa1) !== fm(va(1)))
      begin n_fail++; $display("FAIL bp_hold got=%h exp=%h", out_fa0 ^ out_fa1, fm(va(1))); end
  endtask

  task automatic test_full_simul();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; set_beat(next_in); #1;
      n_cmp++; if (in_ready !== 1'b1 || level !== 3'(DEPTH))
        begin n_fail++; $display("FAIL simul_ready_level got=%b/%0d exp=1/%0d", in_ready, level, DEPTH); end
      n_cmp++; if ((out_fa0 ^ out_fa1) !== fm(va(next_out)) || (out_fb0 ^ out_fb1) !== fm(vb(next_out)))
        begin n_fail++; $display("FAIL simul_order beat=%0d got=%h exp=%h", next_out, out_fa0 ^ out_fa1, fm(va(next_out))); end
      next_out++; next_in++;
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && next_out != next_in; c++) begin
      #1;
      if (out_valid) begin
        n_cmp++; if ((out_fa0 ^ out_fa1) !== fm(va(next_out)) || (out_fb0 ^ out_fb1) !== fm(vb(next_out)))
          begin n_fail++; $display("FAIL drain_order beat=%0d got=%h exp=%h", next_out, out_fa0 ^ out_fa1, fm(va(next_out))); end
        next_out++;
      end
      @(negedge clk);
    end
    n_cmp++; if (next_out != next_in) begin n_fail++; $display("FAIL drain_timeout got=%0d exp=%0d", next_out, next_in); end
    @(negedge clk); #1;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0d/%b exp=0/0", level, out_valid); end
  endtask

  task automatic fill_two();
    int c;
    c = 0;
    out_ready = 1'b0;
    do begin
      @(negedge clk); in_valid = 1'b1; set_beat(c + 7); #1; c++;
    end while (level !== 3'd2 && c < 10);
  endtask

  task automatic test_flush();
    logic seen;
    fill_two();
    n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL flush_fill got=%0d exp=2", level); end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/0/1", level, out_valid, in_ready); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); #1; seen = seen | out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got=%b exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    fill_two();
    in_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_fa0 !== 9'd0)
      begin n_fail++; $display("FAIL rst_mid_clear got=%0d/%b/%b/%h exp=0/0/1/000", level, out_valid, in_ready, out_fa0); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); #1; seen = seen | out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard got=%b exp=0", seen); end
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e;
    int sent, cyc;
    sent = 0; cyc = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      in_a0 = 4'($urandom); in_a1 = 4'($urandom); in_b0 = 4'($urandom); in_b1 = 4'($urandom);
      in_rnd = 8'($urandom);
      in_valid = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        e = (q.size() != 0) ? q.pop_front() : 18'h3FFFF;
        n_cmp++; if ({out_fa0 ^ out_fa1, out_fb0 ^ out_fb1} !== e)
          begin n_fail++; $display("FAIL random_beat got=%h exp=%h", {out_fa0 ^ out_fa1, out_fb0 ^ out_fb1}, e); end
      end
      if (in_valid && in_ready) begin
        q.push_back({fm(in_a0 ^ in_a1), fm(in_b0 ^ in_b1)});
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (sent != 10000 || q.size() != 0) begin n_fail++; $display("FAIL random_timeout got=%0d/%0d exp=10000/0", sent, q.size()); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_remask();
    test_backpressure();
    test_full_simul();
    test_drain();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
